hdmi_tx_timing_gen: RTL

- Transmit-side counterpart of the HDMI receiver frontend.
- Generates progressive or interlaced raster timing (active-low HSYNC/VSYNC, DE, field ID) from runtime configuration.
- Requests pixels by position from an upstream source and drives registered RGB plus syncs to the HDMI transmitter.
- Field signalling follows the receiver's convention, so looping the outputs back into the receiver frontend reproduces FID, interlace flag and positions.

---
 rtl/hdmi_tx_timing_gen_if.sv | 16 +
 rtl/hdmi_tx_timing_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_tx_timing_gen_if.sv
// Pixel request bus between the timing generator and the upstream pixel source.
// The generator (master) publishes the requested position and a request flag.
// The source (slave) answers with RGB within the cycle in which req_o is high.
interface hdmi_tx_timing_gen_if;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic        req_o;
    logic [7:0]  R_i;
    logic [7:0]  G_i;
    logic [7:0]  B_i;

    modport master (output xpos, output ypos, output req_o,
                    input  R_i,  input  G_i,  input  B_i);
    modport slave  (input  xpos, input  ypos, input  req_o,
                    output R_i,  output G_i,  output B_i);
endinterface

// File: rtl/hdmi_tx_timing_gen.sv
// HDMI transmit raster generator: progressive or interlaced timing with
// active-low syncs, DE and field ID. Pixels are requested by position from an
// upstream source, and RGB is registered alongside the syncs.
// Pipeline: stage 0 = counters, stage 1 = request/position + delayed syncs,
// stage 2 = output registers (two cycles from counter to pins).
module hdmi_tx_timing_gen (
    input  logic        PCLK_i,
    input  logic        reset,
    input  logic [11:0] H_TOTAL,
    input  logic [10:0] H_ACTIVE,
    input  logic [7:0]  H_SYNCLEN,
    input  logic [8:0]  H_BACKPORCH,
    input  logic [10:0] V_TOTAL,
    input  logic [10:0] V_ACTIVE,
    input  logic [3:0]  V_SYNCLEN,
    input  logic [8:0]  V_BACKPORCH,
    input  logic        INTERLACED,
    hdmi_tx_timing_gen_if.master pix,
    output logic [7:0]  R_o,
    output logic [7:0]  G_o,
    output logic [7:0]  B_o,
    output logic        HSYNC_o,
    output logic        VSYNC_o,
    output logic        DE_o,
    output logic        FID_o,
    output logic        frame_start
);

    // Shadowed configuration (stable for a whole frame)
    logic [11:0] h_total_q;
    logic [10:0] h_active_q;
    logic [7:0]  h_synclen_q;
    logic [8:0]  h_backporch_q;
    logic [10:0] v_total_q;
    logic [10:0] v_active_q;
    logic [3:0]  v_synclen_q;
    logic [8:0]  v_backporch_q;
    logic        interlaced_q;

    // Stage 0 counters; fid_q = 1 means odd/first field
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        fid_q, fid_d;
    logic        frame_wrap;

    // Stage 1
    logic [10:0] xpos_q, xpos_d;
    logic [10:0] ypos_q, ypos_d;
    logic        req_q;
    logic        hs_s1_q, vs_s1_q, fid_s1_q, fs_s1_q;

    // Stage 2 (output registers)
    logic [7:0]  r_q, g_q, b_q;
    logic        hsync_q, vsync_q, de_q, fid_out_q, frame_start_q;

    // Decoded position of the current counter value
    logic [12:0] h_act_start, h_act_end;
    logic [11:0] v_act_start, v_act_end;
    logic [11:0] h_half;
    logic [10:0] field_lines;
    logic [10:0] v_sync_end;
    logic        h_last, v_last;
    logic        h_act, v_act, req_s0;
    logic        hs_s0, vs_s0, fs_s0;

    assign h_act_start = {5'd0, h_synclen_q} + {4'd0, h_backporch_q};
    assign h_act_end   = h_act_start + {2'd0, h_active_q};
    assign v_act_start = {8'd0, v_synclen_q} + {3'd0, v_backporch_q};
    assign v_act_end   = v_act_start + {1'b0, v_active_q};
    assign h_half      = {1'b0, h_total_q[11:1]};
    assign v_sync_end  = {7'd0, v_synclen_q};

    // Odd field takes the extra line when the frame line count is odd
    always_comb begin
        field_lines = v_total_q;
        if (interlaced_q) begin
            if (fid_q) begin
                field_lines = {1'b0, v_total_q[10:1]} + {10'd0, v_total_q[0]};
            end else begin
                field_lines = {1'b0, v_total_q[10:1]};
            end
        end
    end

    // ">=" compares keep the counters bounded if a total shrinks
    assign h_last = ({1'b0, h_cnt_q} + 13'd1) >= {1'b0, h_total_q};
    assign v_last = ({1'b0, v_cnt_q} + 12'd1) >= {1'b0, field_lines};

    assign h_act  = ({1'b0, h_cnt_q} >= h_act_start) && ({1'b0, h_cnt_q} < h_act_end);
    assign v_act  = ({1'b0, v_cnt_q} >= v_act_start) && ({1'b0, v_cnt_q} < v_act_end);
    assign req_s0 = h_act && v_act;
    assign hs_s0  = h_cnt_q < {4'd0, h_synclen_q};
    assign fs_s0  = (h_cnt_q == 12'd0) && (v_cnt_q == 11'd0) && fid_q;

    // VSYNC window; the even field shifts both edges by half a line
    always_comb begin
        if (fid_q) begin
            vs_s0 = v_cnt_q < v_sync_end;
        end else begin
            vs_s0 = ((v_cnt_q != 11'd0) || (h_cnt_q >= h_half)) &&
                    ((v_cnt_q < v_sync_end) ||
                     ((v_cnt_q == v_sync_end) && (h_cnt_q < h_half)));
        end
    end

    // Next counter/field state; a frame begins on the wrap into the odd field
    always_comb begin
        h_cnt_d    = h_cnt_q + 12'd1;
        v_cnt_d    = v_cnt_q;
        fid_d      = fid_q;
        frame_wrap = 1'b0;
        if (h_last) begin
            h_cnt_d = 12'd0;
            if (v_last) begin
                v_cnt_d = 11'd0;
                if (interlaced_q && fid_q) begin
                    fid_d = 1'b0;
                end else begin
                    fid_d      = 1'b1;
                    frame_wrap = 1'b1;
                end
            end else begin
                v_cnt_d = v_cnt_q + 11'd1;
            end
        end
    end

    // Stage 1 position: xpos is 0 outside requests, ypos holds between fields
    always_comb begin
        xpos_d = 11'd0;
        ypos_d = ypos_q;
        if (req_s0) begin
            xpos_d = h_cnt_q[10:0] - h_act_start[10:0];
        end
        if (v_act) begin
            ypos_d = v_cnt_q - v_act_start[10:0];
        end
    end

    // Capture configuration during reset and at each frame boundary
    always_ff @(posedge PCLK_i) begin
        if (reset || frame_wrap) begin
            h_total_q     <= H_TOTAL;
            h_active_q    <= H_ACTIVE;
            h_synclen_q   <= H_SYNCLEN;
            h_backporch_q <= H_BACKPORCH;
            v_total_q     <= V_TOTAL;
            v_active_q    <= V_ACTIVE;
            v_synclen_q   <= V_SYNCLEN;
            v_backporch_q <= V_BACKPORCH;
            interlaced_q  <= INTERLACED;
        end
    end

    // Stage 0: raster counters and field ID
    always_ff @(posedge PCLK_i) begin
        if (reset) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= 11'd0;
            fid_q   <= 1'b1;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            fid_q   <= fid_d;
        end
    end

    // Stage 1: pixel request to the source plus delayed timing flags
    always_ff @(posedge PCLK_i) begin
        if (reset) begin
            xpos_q   <= 11'd0;
            ypos_q   <= 11'd0;
            req_q    <= 1'b0;
            hs_s1_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            fid_s1_q <= 1'b1;
            fs_s1_q  <= 1'b0;
        end else begin
            xpos_q   <= xpos_d;
            ypos_q   <= ypos_d;
            req_q    <= req_s0;
            hs_s1_q  <= hs_s0;
            vs_s1_q  <= vs_s0;
            fid_s1_q <= fid_q;
            fs_s1_q  <= fs_s0;
        end
    end

    // Stage 2: registered outputs; RGB blanked whenever DE is low
    always_ff @(posedge PCLK_i) begin
        if (reset) begin
            r_q           <= 8'd0;
            g_q           <= 8'd0;
            b_q           <= 8'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            fid_out_q     <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            r_q           <= req_q ? pix.R_i : 8'd0;
            g_q           <= req_q ? pix.G_i : 8'd0;
            b_q           <= req_q ? pix.B_i : 8'd0;
            hsync_q       <= ~hs_s1_q;
            vsync_q       <= ~vs_s1_q;
            de_q          <= req_q;
            fid_out_q     <= fid_s1_q;
            frame_start_q <= fs_s1_q;
        end
    end

    assign pix.xpos    = xpos_q;
    assign pix.ypos    = ypos_q;
    assign pix.req_o   = req_q;
    assign R_o         = r_q;
    assign G_o         = g_q;
    assign B_o         = b_q;
    assign HSYNC_o     = hsync_q;
    assign VSYNC_o     = vsync_q;
    assign DE_o        = de_q;
    assign FID_o       = fid_out_q;
    assign frame_start = frame_start_q;

endmodule
